// File: rtl/forward_unit.sv
// Execute-stage bypass selector: picks the newest producer of each ALU source operand.
// Optional per-path usage counters are compiled in with FORWARD_STATS_EN.
module forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Registro1,
    input  logic [REG_ADDR_W-1:0] Registro2,
    input  logic [REG_ADDR_W-1:0] Rd_execute,
    input  logic [REG_ADDR_W-1:0] Rd_writeback,
    input  logic                  ex_regwrite,
    input  logic                  wb_regwrite,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB
`ifdef FORWARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      fwd_ex_count,
    output logic [CNT_W-1:0]      fwd_wb_count
`endif
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b01;

    // EX/MEM is checked first since it carries the younger write; x0 never matches.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] rd_ex,
        input logic [REG_ADDR_W-1:0] rd_wb,
        input logic                  ex_we,
        input logic                  wb_we
    );
        logic [1:0] sel;
        if (ex_we && (rd_ex != {REG_ADDR_W{1'b0}}) && (rd_ex == src)) begin
            sel = SEL_EX;
        end else if (wb_we && (rd_wb != {REG_ADDR_W{1'b0}}) && (rd_wb == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // Operand select generation, forced to register-file values during reset.
    always_comb begin
        fwd_a_s = SEL_RF;
        fwd_b_s = SEL_RF;
        if (rst) begin
            fwd_a_s = SEL_RF;
            fwd_b_s = SEL_RF;
        end else begin
            fwd_a_s = fwd_sel(Registro1, Rd_execute, Rd_writeback, ex_regwrite, wb_regwrite);
            fwd_b_s = fwd_sel(Registro2, Rd_execute, Rd_writeback, ex_regwrite, wb_regwrite);
        end
    end

    assign forwardA = fwd_a_s;
    assign forwardB = fwd_b_s;

`ifdef FORWARD_STATS_EN
    // Adds 0..2 and clamps at all-ones so the counter never wraps.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] res;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            res = {CNT_W{1'b1}};
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    logic [1:0]       ex_inc_s;
    logic [1:0]       wb_inc_s;
    logic [CNT_W-1:0] fwd_ex_count_r;
    logic [CNT_W-1:0] fwd_wb_count_r;

    // Per-cycle number of operands taken from each bypass path.
    always_comb begin
        ex_inc_s = {1'b0, (fwd_a_s == SEL_EX)} + {1'b0, (fwd_b_s == SEL_EX)};
        wb_inc_s = {1'b0, (fwd_a_s == SEL_WB)} + {1'b0, (fwd_b_s == SEL_WB)};
    end

    // Usage counters; a reset cycle clears them and its forwards are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_ex_count_r <= {CNT_W{1'b0}};
            fwd_wb_count_r <= {CNT_W{1'b0}};
        end else begin
            fwd_ex_count_r <= sat_add(fwd_ex_count_r, ex_inc_s);
            fwd_wb_count_r <= sat_add(fwd_wb_count_r, wb_inc_s);
        end
    end

    assign fwd_ex_count = fwd_ex_count_r;
    assign fwd_wb_count = fwd_wb_count_r;
`else
    logic             unused_clk_s;
    logic [CNT_W-1:0] unused_cnt_s;
    assign unused_clk_s = clk;
    assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Self-checking bench for forward_unit: directed cases plus randomized traffic
// compared against a behavioural model; counters checked when FORWARD_STATS_EN is set.
module tb_forward_unit;

    localparam int AW     = 5;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] r1, r2, rd_ex, rd_wb;
    logic          ex_we, wb_we;
    logic [1:0]    fwd_a, fwd_b;
`ifdef FORWARD_STATS_EN
    logic [CW-1:0] ex_cnt, wb_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int m_ex_cnt = 0;
    int m_wb_cnt = 0;

    forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .Registro1    (r1),
        .Registro2    (r2),
        .Rd_execute   (rd_ex),
        .Rd_writeback (rd_wb),
        .ex_regwrite  (ex_we),
        .wb_regwrite  (wb_we),
        .forwardA     (fwd_a),
        .forwardB     (fwd_b)
`ifdef FORWARD_STATS_EN
        ,
        .fwd_ex_count (ex_cnt),
        .fwd_wb_count (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: source index of the newest writer of src, as a select code.
    function automatic int model_sel(int src, int rst_i, int exw, int rde, int wbw, int rdw);
        if (rst_i != 0 || src == 0) return 0;
        if (exw != 0 && rde == src) return 2;
        if (wbw != 0 && rdw == src) return 1;
        return 0;
    endfunction

    task automatic do_cycle(input int rst_i, input int a1, input int a2, input int rde,
                            input int rdw, input int exw, input int wbw, input string tag);
        int ea, eb;
        @(negedge clk);
        rst = rst_i[0]; r1 = a1[AW-1:0]; r2 = a2[AW-1:0];
        rd_ex = rde[AW-1:0]; rd_wb = rdw[AW-1:0]; ex_we = exw[0]; wb_we = wbw[0];
        #1;
        ea = model_sel(a1, rst_i, exw, rde, wbw, rdw);
        eb = model_sel(a2, rst_i, exw, rde, wbw, rdw);
        check_val({tag, ".fwdA"}, {30'd0, fwd_a}, ea);
        check_val({tag, ".fwdB"}, {30'd0, fwd_b}, eb);
        if (rst_i != 0) begin
            m_ex_cnt = 0;
            m_wb_cnt = 0;
        end else begin
            m_ex_cnt += (ea == 2) + (eb == 2);
            m_wb_cnt += (ea == 1) + (eb == 1);
            if (m_ex_cnt > CNTMAX) m_ex_cnt = CNTMAX;
            if (m_wb_cnt > CNTMAX) m_wb_cnt = CNTMAX;
        end
        @(posedge clk);
        #1;
`ifdef FORWARD_STATS_EN
        check_val({tag, ".ex_cnt"}, {28'd0, ex_cnt}, m_ex_cnt);
        check_val({tag, ".wb_cnt"}, {28'd0, wb_cnt}, m_wb_cnt);
`endif
    endtask

    initial begin
        rst = 1'b1; r1 = '0; r2 = '0; rd_ex = '0; rd_wb = '0; ex_we = 1'b0; wb_we = 1'b0;
        do_cycle(1, 3, 4, 1, 2, 1, 1, "reset");
        do_cycle(0, 3, 4, 1, 2, 0, 0, "nofwd");
        do_cycle(0, 3, 4, 3, 2, 1, 0, "ex_a");
        do_cycle(0, 3, 4, 1, 3, 0, 1, "wb_a");
        do_cycle(0, 3, 4, 4, 2, 1, 0, "ex_b");
        do_cycle(0, 3, 4, 1, 4, 0, 1, "wb_b");
        do_cycle(0, 3, 4, 4, 3, 1, 1, "split");
        do_cycle(0, 5, 4, 5, 5, 1, 1, "prio");
        do_cycle(0, 0, 0, 0, 0, 1, 1, "x0");
        do_cycle(0, 5, 5, 5, 5, 1, 1, "prio2");
        do_cycle(1, 5, 5, 5, 5, 1, 1, "rstgate");
        // Three double-EX cycles then +2 steps up to and through saturation.
        for (int i = 0; i < 3; i++) do_cycle(0, 7, 7, 7, 1, 1, 1, "ex3");
        for (int i = 0; i < 5; i++) do_cycle(0, 6, 6, 6, 0, 1, 0, "sat");
        do_cycle(1, 6, 6, 6, 6, 1, 1, "rst1");
        for (int i = 0; i < 9; i++) do_cycle(0, 9, 9, 2, 9, 1, 1, "satwb");
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 39) == 0) ? 1 : 0,
                     $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 1), "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
